// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared definitions for the M-stage memory access unit.
//   - exception codes reported to CP0
//   - access size encodings (2'b11 is illegal and handled as a word)
//   - FSM state encoding
//   - byte-enable and store-lane helpers used by the top level
package mem_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DM_RD    = 2'b01,
    ST_DEV_WAIT = 2'b10
  } state_t;

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the low byte/half across all lanes so the enables pick the right one.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    store_lanes = {4{data[7:0]}};
      SZ_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response, data-memory port and
// device-bridge port of the memory access unit.
//   slave  : the unit itself (consumes requests, drives strobes/responses)
//   master : the surrounding pipeline, DM and bridge
interface mem_access_unit_if #(
  parameter int NUM_DEV = 2
);
  // pipeline request
  logic               req_valid;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_signed;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [4:0]         exc_in;
  logic               int_req;
  // pipeline response
  logic               stall;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic [4:0]         exc_out;
  // data memory
  logic               dm_en;
  logic               dm_we;
  logic [3:0]         dm_be;
  logic [31:0]        dm_addr;
  logic [31:0]        dm_wdata;
  logic [31:0]        dm_rdata;
  // device bridge
  logic               pr_req;
  logic               pr_we;
  logic [NUM_DEV-1:0] pr_sel;
  logic [31:0]        pr_addr;
  logic [31:0]        pr_wdata;
  logic               pr_ack;
  logic [31:0]        pr_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, exc_in, int_req,
    output stall, rsp_valid, rsp_rdata, exc_out,
    output dm_en, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata,
    output pr_req, pr_we, pr_sel, pr_addr, pr_wdata,
    input  pr_ack, pr_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, exc_in, int_req,
    input  stall, rsp_valid, rsp_rdata, exc_out,
    input  dm_en, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata,
    input  pr_req, pr_we, pr_sel, pr_addr, pr_wdata,
    output pr_ack, pr_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the addressed byte/half lane out of a 32-bit word and
// zero- or sign-extends it. Shared by the DM and device read paths.
//   size_i   : access size (SZ_B/SZ_H/word)
//   signed_i : sign-extend when 1
//   off_i    : byte offset addr[1:0]
//   word_i   : raw 32-bit read word
//   data_o   : extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    case (off_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      default: byte_s = word_i[31:24];
    endcase
    half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_B:    data_o = {{24{signed_i & byte_s[7]}}, byte_s};
      SZ_H:    data_o = {{16{signed_i & half_s[15]}}, half_s};
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; forces every output to 0
//   bus   : request/response, DM port and device bridge (slave modport)
// DM stores complete in the accept cycle; DM loads take one extra cycle for
// the registered read; device accesses wait for pr_ack up to TIMEOUT cycles
// of pr_req, after which a bus error (DBE) is reported.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          DM_BYTES   = 12288,
  parameter int          NUM_DEV    = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
  parameter int          DEV_STRIDE = 16,
  parameter int          DEV_BYTES  = 12,
  parameter int          TIMEOUT    = 15
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap_we_q, cap_we_d;
  logic [1:0]         cap_size_q, cap_size_d;
  logic               cap_signed_q, cap_signed_d;
  logic [31:0]        cap_addr_q, cap_addr_d;
  logic [31:0]        cap_wdata_q, cap_wdata_d;
  logic [NUM_DEV-1:0] cap_sel_q, cap_sel_d;

  logic               dm_hit_s, dev_hit_s, misalign_s, addr_err_s;
  logic [NUM_DEV-1:0] dev_sel_s;
  logic [31:0]        align_word_s, align_data_s;

  assign align_word_s = (state_q == ST_DM_RD) ? bus.dm_rdata : bus.pr_rdata;

  load_align u_align (
    .size_i   (cap_size_q),
    .signed_i (cap_signed_q),
    .off_i    (cap_addr_q[1:0]),
    .word_i   (align_word_s),
    .data_o   (align_data_s)
  );

  // Address map decode and alignment check for the incoming request.
  always_comb begin
    dm_hit_s = (bus.req_addr < 32'(DM_BYTES));
    for (int i = 0; i < NUM_DEV; i++) begin
      if ((bus.req_addr >= DEV_BASE + 32'(i * DEV_STRIDE)) &&
          ((bus.req_addr - (DEV_BASE + 32'(i * DEV_STRIDE))) < 32'(DEV_BYTES))) begin
        dev_sel_s[i] = 1'b1;
      end else begin
        dev_sel_s[i] = 1'b0;
      end
    end
    dev_hit_s  = (|dev_sel_s) & ~dm_hit_s;
    // size 2'b11 behaves as a word, hence testing req_size[1]
    misalign_s = ((bus.req_size == SZ_H) & bus.req_addr[0]) |
                 (bus.req_size[1] & (|bus.req_addr[1:0]));
    addr_err_s = misalign_s | (~dm_hit_s & ~dev_hit_s) | (dev_hit_s & ~bus.req_size[1]);
  end

  // Next-state, capture and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_we_d     = cap_we_q;
    cap_size_d   = cap_size_q;
    cap_signed_d = cap_signed_q;
    cap_addr_d   = cap_addr_q;
    cap_wdata_d  = cap_wdata_q;
    cap_sel_d    = cap_sel_q;
    bus.stall     = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0000_0000;
    bus.exc_out   = EXC_NONE;
    bus.dm_en     = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_be     = 4'b0000;
    bus.dm_addr   = 32'h0000_0000;
    bus.dm_wdata  = 32'h0000_0000;
    bus.pr_req    = 1'b0;
    bus.pr_we     = 1'b0;
    bus.pr_sel    = {NUM_DEV{1'b0}};
    bus.pr_addr   = 32'h0000_0000;
    bus.pr_wdata  = 32'h0000_0000;

    if (!reset) begin
      // outputs stay at their zero defaults while reset is held
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.req_valid) begin
            state_d = ST_IDLE;
          end else if (bus.exc_in != EXC_NONE) begin
            bus.rsp_valid = 1'b1;
            bus.exc_out   = bus.exc_in;
          end else if (addr_err_s) begin
            bus.rsp_valid = 1'b1;
            bus.exc_out   = bus.req_we ? EXC_ADES : EXC_ADEL;
          end else if (bus.int_req) begin
            bus.rsp_valid = 1'b1;
            bus.exc_out   = bus.exc_in;
          end else begin
            cap_we_d     = bus.req_we;
            cap_size_d   = bus.req_size;
            cap_signed_d = bus.req_signed;
            cap_addr_d   = bus.req_addr;
            cap_wdata_d  = bus.req_wdata;
            cap_sel_d    = dev_sel_s;
            if (dm_hit_s) begin
              bus.dm_en   = 1'b1;
              bus.dm_be   = byte_en(bus.req_size, bus.req_addr[1:0]);
              bus.dm_addr = {bus.req_addr[31:2], 2'b00};
              if (bus.req_we) begin
                bus.dm_we     = 1'b1;
                bus.dm_wdata  = store_lanes(bus.req_size, bus.req_wdata);
                bus.rsp_valid = 1'b1;
              end else begin
                bus.stall = 1'b1;
                state_d   = ST_DM_RD;
              end
            end else begin
              // accept cycle already counts as the first pr_req cycle
              bus.pr_req   = 1'b1;
              bus.pr_we    = bus.req_we;
              bus.pr_sel   = dev_sel_s;
              bus.pr_addr  = bus.req_addr;
              bus.pr_wdata = bus.req_wdata;
              bus.stall    = 1'b1;
              cnt_d        = CNT_W'(1);
              state_d      = ST_DEV_WAIT;
            end
          end
        end
        ST_DM_RD: begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = align_data_s;
          state_d       = ST_IDLE;
        end
        ST_DEV_WAIT: begin
          // cnt_q == CNT_LIMIT means TIMEOUT request cycles have gone unanswered
          if (cnt_q != CNT_LIMIT) begin
            bus.pr_req   = 1'b1;
            bus.pr_we    = cap_we_q;
            bus.pr_sel   = cap_sel_q;
            bus.pr_addr  = cap_addr_q;
            bus.pr_wdata = cap_wdata_q;
          end else begin
            bus.pr_req = 1'b0;
          end
          if (bus.pr_ack) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = cap_we_q ? 32'h0000_0000 : align_data_s;
            cnt_d         = {CNT_W{1'b0}};
            state_d       = ST_IDLE;
          end else if (cnt_q == CNT_LIMIT) begin
            bus.rsp_valid = 1'b1;
            bus.exc_out   = EXC_DBE;
            cnt_d         = {CNT_W{1'b0}};
            state_d       = ST_IDLE;
          end else begin
            bus.stall = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, wait counter and captured request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      cap_we_q     <= 1'b0;
      cap_size_q   <= 2'b00;
      cap_signed_q <= 1'b0;
      cap_addr_q   <= 32'h0000_0000;
      cap_wdata_q  <= 32'h0000_0000;
      cap_sel_q    <= {NUM_DEV{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_we_q     <= cap_we_d;
      cap_size_q   <= cap_size_d;
      cap_signed_q <= cap_signed_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_sel_q    <= cap_sel_d;
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised M-stage memory access unit for the pipelined MIPS core.
- Decodes each load or store against a configurable address map: data memory plus NUM_DEV memory-mapped devices.
- Generates byte enables and lane-replicated store data; aligns and extends load data; raises AdEL/AdES/DBE exception codes.
- Unlike the single-cycle predecessor, it supports a synchronous-read DM and variable-latency devices through a req/ack bridge, stalling the pipeline while it waits and enforcing a timeout.

Parameters:
- DM_BYTES, 12288: DM occupies [0, DM_BYTES-1]; must be a multiple of 4.
- NUM_DEV, 2: number of devices, 1..8.
- DEV_BASE, 32'h7f00: byte address of device 0.
- DEV_STRIDE, 16: address spacing between consecutive devices.
- DEV_BYTES, 12: bytes decoded per device; word access only.
- TIMEOUT, 15: cycles to wait for pr_ack before declaring a bus error; at least 1.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  the M-stage instruction is a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- req_signed  in  1  sign-extend the load result (lb/lh).
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data, already forwarded.
- exc_in  in  5  exception code from earlier stages; 0 = none.
- int_req  in  1  interrupt pending this cycle; kills the access.
- stall  out  1  freeze IF..M this cycle.
- rsp_valid  out  1  access completed this cycle.
- rsp_rdata  out  32  extended load data; valid with rsp_valid.
- exc_out  out  5  exception code to CP0.
- dm_en  out  1  DM access strobe.
- dm_we  out  1  DM write strobe.
- dm_be  out  4  DM byte enables.
- dm_addr  out  32  DM word address (bits [1:0] = 0).
- dm_wdata  out  32  DM write data.
- dm_rdata  in  32  DM read data, registered, available 1 cycle after dm_en.
- pr_req  out  1  bridge request.
- pr_we  out  1  bridge write.
- pr_sel  out  NUM_DEV  one-hot device select.
- pr_addr  out  32  bridge address.
- pr_wdata  out  32  bridge write data.
- pr_ack  in  1  device done.
- pr_rdata  in  32  device read data; valid with pr_ack.

Behaviour:
- States: IDLE, DM_RD, DEV_WAIT.
- Reset (reset=0, asynchronous):
  - state=IDLE, timeout counter=0, captured request cleared.
  - All outputs 0.
  - Reset mid-operation abandons the access; pr_req drops immediately.
- IDLE, req_valid=1, address check (combinational, same cycle):
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) is an address error.
  - An address outside DM and outside every device window is an address error.
  - A byte or half access to a device is an address error.
  - Address error gives exc_out = 5 (AdES) for a store, 4 (AdEL) for a load.
- IDLE, no access issued: no strobes, stall=0, rsp_valid=1, rsp_rdata=0, when any of:
  - exc_in != 0: exc_out = exc_in, which has priority over address errors.
  - An address error (above).
  - int_req=1: exc_out = exc_in.
- IDLE, DM store:
  - dm_en=1, dm_we=1.
  - dm_be: byte = 1 << addr[1:0]; half = 0011 or 1100 selected by addr[1]; word = 1111.
  - dm_wdata: byte replicated to all 4 lanes, half to both halves.
  - Completes the same cycle: stall=0, rsp_valid=1.
- IDLE, DM load:
  - dm_en=1, stall=1; capture size, signed and addr[1:0]; go to DM_RD.
- DM_RD:
  - stall=0, rsp_valid=1.
  - rsp_rdata = the selected lane of dm_rdata, zero- or sign-extended.
  - Return to IDLE.
- IDLE, device access:
  - Capture the request; assert pr_req, pr_sel and pr_we; go to DEV_WAIT; stall=1.
- DEV_WAIT:
  - Hold pr_req and the bridge outputs stable; count cycles.
  - pr_ack=1: stall=0, rsp_valid=1, rsp_rdata=pr_rdata (loads), pr_req=0 next cycle, return to IDLE.
  - Counter reaches TIMEOUT without ack: exc_out=7 (DBE), rsp_valid=1, stall=0, drop pr_req, return to IDLE.
  - pr_ack on the timeout cycle counts as success.
- int_req is sampled only in the IDLE accept cycle; in DM_RD or DEV_WAIT it is ignored and CP0 takes it after completion.
- Request inputs are held stable by the pipeline while stall=1; the unit uses its captured copy regardless.
- pr_ack received in IDLE is ignored.

Decomposition:
- Shared package mem_pkg:
  - Exception codes: EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7.
  - Size encodings SZ_B, SZ_H, SZ_W.
  - State encoding.
- Sub-module load_align: combinational lane select plus sign/zero extension (size, signed, offset, word -> 32-bit), shared by the DM and device paths.

Test Plan:
- sb at 0x0000_0013, wdata 0x0000_00A5 -> dm_be=1000, dm_wdata=0xA5A5A5A5, stall=0, rsp_valid=1 the same cycle.
- lh at 0x0000_0102 with the DM word at 0x100 = 0x8001_7FFF, req_signed=1 -> stall 1 cycle, then rsp_rdata=0xFFFF8001; with req_signed=0 -> 0x00008001.
- lw at 0x0000_0006 -> exc_out=4, no dm_en; sw at 0x0000_3000 with DM_BYTES=12288 -> exc_out=5, no strobes; sh at 0x7f04 -> exc_out=5.
- lw at 0x7f14, pr_ack after 3 cycles with pr_rdata=0x1234_5678 -> pr_sel=10, stall for 3 cycles, rsp_rdata=0x12345678.
- sw to 0x7f00 with no ack and TIMEOUT=15 -> pr_req high 15 cycles, then exc_out=7, stall=0.
- sw at 0x40 with int_req=1 -> dm_we=0, exc_out=exc_in; reset=0 during DEV_WAIT -> pr_req=0 asynchronously, state IDLE.
